// File: rtl/ysyx_25040118_pkg.sv
// Shared types and constants for the ysyx_25040118 load/store unit.
// Holds the FSM state encoding, funct3 codes, strobe patterns and access-size decode.
package ysyx_25040118_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_WB   = 3'd3,
        S_ERR  = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Unknown funct3 codes fall back to a word access.
    function automatic size_e f3_size(input logic [2:0] f3);
        size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            default:     sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/ysyx_25040118_lsu_align.sv
// Combinational lane steering: store strobes/data replication, load extraction
// and extension, and misalignment detection.
module ysyx_25040118_lsu_align
    import ysyx_25040118_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [31:0] shifted_s;

    // Store-side lane steering and alignment check.
    always_comb begin
        wstrb    = STRB_W;
        wdata    = st_data;
        misalign = 1'b0;
        case (f3_size(funct3))
            SZ_B: begin
                wstrb = STRB_B << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                wstrb    = STRB_H << addr_lo;
                wdata    = {2{st_data[15:0]}};
                misalign = addr_lo[0];
            end
            default: begin
                wstrb    = STRB_W;
                wdata    = st_data;
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

    // Load-side shift to lane 0 followed by sign/zero extension.
    always_comb begin
        shifted_s = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_BU:   ld_data = {24'h000000, shifted_s[7:0]};
            F3_H:    ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_HU:   ld_data = {16'h0000, shifted_s[15:0]};
            default: ld_data = shifted_s;
        endcase
    end

endmodule

// File: rtl/ysyx_25040118_lsu.sv
// Load/store and writeback unit: accepts one execute result at a time, runs the
// req/gnt/rvalid bus for memory ops and drives the register file write port.
module ysyx_25040118_lsu
    import ysyx_25040118_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RF_AW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem,
    input  logic              in_store,
    input  logic [2:0]        in_funct3,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [RF_AW-1:0]  in_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              rf_wen,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic              done,
    output logic              misalign
);

    lsu_state_e        state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [RF_AW-1:0]  rd_q, rd_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic              rf_wen_q, rf_wen_d;
    logic [RF_AW-1:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;
    logic              done_q, done_d;
    logic              misalign_q, misalign_d;

    logic              accept_s;
    logic [2:0]        al_funct3_s;
    logic [1:0]        al_addr_lo_s;
    logic [3:0]        al_wstrb_s;
    logic [31:0]       al_wdata_s;
    logic [31:0]       al_ld_data_s;
    logic              al_misalign_s;
    logic [RF_AW-1:0]  wb_rd_s;

    assign in_ready = (state_q == S_IDLE);
    assign accept_s = in_valid && (state_q == S_IDLE);

    // The aligner sees live inputs while idle and the latched request afterwards.
    assign al_funct3_s  = (state_q == S_IDLE) ? in_funct3    : funct3_q;
    assign al_addr_lo_s = (state_q == S_IDLE) ? in_addr[1:0] : addr_lo_q;
    assign wb_rd_s      = (state_q == S_IDLE) ? in_rd        : rd_q;

    ysyx_25040118_lsu_align u_align (
        .funct3   (al_funct3_s),
        .addr_lo  (al_addr_lo_s),
        .st_data  (in_wdata),
        .rdata    (mem_rdata),
        .wstrb    (al_wstrb_s),
        .wdata    (al_wdata_s),
        .ld_data  (al_ld_data_s),
        .misalign (al_misalign_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!in_valid) begin
                    state_d = S_IDLE;
                end else if (!in_mem) begin
                    state_d = S_WB;
                end else if (al_misalign_s) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!mem_gnt) begin
                    state_d = S_REQ;
                end else if (store_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of latched request fields and registered outputs.
    always_comb begin
        store_d     = store_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;

        if (accept_s) begin
            store_d   = in_mem && in_store;
            funct3_d  = in_funct3;
            addr_lo_d = in_addr[1:0];
            rd_d      = in_rd;
        end else begin
            store_d = store_q;
        end

        if (accept_s && (state_d == S_REQ)) begin
            mem_addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
            mem_wdata_d = al_wdata_s;
            mem_wstrb_d = al_wstrb_s;
        end else begin
            mem_addr_d = mem_addr_q;
        end

        if (accept_s && !in_mem) begin
            rf_waddr_d = in_rd;
            rf_wdata_d = in_wdata;
        end else if ((state_q == S_WAIT) && mem_rvalid) begin
            rf_waddr_d = rd_q;
            rf_wdata_d = al_ld_data_s;
        end else begin
            rf_waddr_d = rf_waddr_q;
        end

        mem_req_d  = (state_d == S_REQ);
        mem_we_d   = (state_d == S_REQ) && ((state_q == S_IDLE) ? in_store : store_q);
        rf_wen_d   = (state_d == S_WB) && (wb_rd_s != {RF_AW{1'b0}});
        misalign_d = (state_d == S_ERR);
        done_d     = (state_d == S_WB) || (state_d == S_ERR)
                  || ((state_q == S_REQ) && mem_gnt && store_q);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            rd_q        <= {RF_AW{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= {RF_AW{1'b0}};
            rf_wdata_q  <= 32'h0000_0000;
            done_q      <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            rd_q        <= rd_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            done_q      <= done_d;
            misalign_q  <= misalign_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign rf_wen    = rf_wen_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign done      = done_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_ysyx_25040118_lsu.sv
// Scoreboard bench for ysyx_25040118_lsu: stimulus pushes expected retirements
// and bus requests, a negedge monitor pops and compares them.
module tb_ysyx_25040118_lsu;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
    } ret_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_mem, in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        rf_wen, done, misalign;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks   = 0;
    int failures = 0;
    ret_t ret_q[$];
    bus_t bus_q[$];

    always #5 clk = ~clk;

    ysyx_25040118_lsu #(.ADDR_W(32), .RF_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mem(in_mem), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .done(done), .misalign(misalign)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: compare every retirement and every granted bus request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done || rf_wen) begin
                if (ret_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_retire: got wen=%0b done=%0b expected none", rf_wen, done);
                end else begin
                    ret_t e;
                    e = ret_q.pop_front();
                    chk("ret_wen", {31'd0, rf_wen}, {31'd0, e.wen});
                    chk("ret_done", {31'd0, done}, 32'd1);
                    chk("ret_misalign", {31'd0, misalign}, {31'd0, e.mis});
                    if (e.wen) begin
                        chk("ret_waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
                        chk("ret_wdata", rf_wdata, e.wdata);
                    end
                end
            end
            if (mem_req && mem_gnt) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bus: got addr=0x%08h expected no request", mem_addr);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    chk("bus_we", {31'd0, mem_we}, {31'd0, b.we});
                    chk("bus_addr", mem_addr, b.addr);
                    if (b.we) begin
                        chk("bus_wdata", mem_wdata, b.wdata);
                        chk("bus_wstrb", {28'd0, mem_wstrb}, {28'd0, b.strb});
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic mem, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        step();
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_mem = mem; in_store = st; in_funct3 = f3;
        in_addr = addr; in_wdata = wd; in_rd = rd;
        step();
        in_valid = 1'b0;
        chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic do_pt(input logic [4:0] rd, input logic [31:0] wd);
        ret_q.push_back('{(rd != 5'd0), rd, wd, 1'b0});
        send(1'b0, 1'b0, 3'b010, 32'h0, wd, rd);
        chk("pt_wen_lat", {31'd0, rf_wen}, {31'd0, (rd != 5'd0)});
        chk("pt_mem_req", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] rdata, input int dly, input logic [31:0] expv);
        bus_q.push_back('{1'b0, {addr[31:2], 2'b00}, 32'h0, 4'h0});
        ret_q.push_back('{(rd != 5'd0), rd, expv, 1'b0});
        send(1'b1, 1'b0, f3, addr, 32'h0, rd);
        chk("ld_req_rise", {31'd0, mem_req}, 32'd1);
        for (int i = 0; i < dly; i++) begin
            chk("ld_req_hold", {31'd0, mem_req}, 32'd1);
            chk("ld_addr_hold", mem_addr, {addr[31:2], 2'b00});
            step();
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("ld_req_drop", {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        chk("ld_wen_lat", {31'd0, rf_wen}, {31'd0, (rd != 5'd0)});
        chk("ld_done", {31'd0, done}, 32'd1);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [31:0] wd, input int dly);
        bus_q.push_back('{1'b1, {addr[31:2], 2'b00}, wd, strb});
        ret_q.push_back('{1'b0, 5'd0, 32'h0, 1'b0});
        send(1'b1, 1'b1, f3, addr, data, 5'd1);
        for (int i = 0; i < dly; i++) begin
            chk("st_req_hold", {31'd0, mem_req}, 32'd1);
            chk("st_we_hold", {31'd0, mem_we}, 32'd1);
            chk("st_addr_hold", mem_addr, {addr[31:2], 2'b00});
            chk("st_wdata_hold", mem_wdata, wd);
            chk("st_wstrb_hold", {28'd0, mem_wstrb}, {28'd0, strb});
            chk("st_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        chk("st_req_at_gnt", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("st_done_lat", {31'd0, done}, 32'd1);
        chk("st_no_wen", {31'd0, rf_wen}, 32'd0);
        chk("st_req_drop", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic do_mis(input logic st, input logic [2:0] f3, input logic [31:0] addr);
        ret_q.push_back('{1'b0, 5'd0, 32'h0, 1'b1});
        send(1'b1, st, f3, addr, 32'h1111_2222, 5'd6);
        chk("mis_done", {31'd0, done}, 32'd1);
        chk("mis_flag", {31'd0, misalign}, 32'd1);
        chk("mis_no_req", {31'd0, mem_req}, 32'd0);
        chk("mis_no_wen", {31'd0, rf_wen}, 32'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
        chk({tag, "_rf_wen"}, {31'd0, rf_wen}, 32'd0);
        chk({tag, "_rf_waddr"}, {27'd0, rf_waddr}, 32'd0);
        chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mem = 1'b0; in_store = 1'b0; in_funct3 = 3'b000;
        in_addr = 32'h0; in_wdata = 32'h0; in_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        step(); step();
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        do_pt(5'd5, 32'h1234_5678);
        do_pt(5'd0, 32'hCAFE_F00D);
        do_pt(5'd20, 32'h0F0F_0F0F);

        do_load(3'b000, 32'h8000_0003, 5'd7, 32'h80AA_BBCC, 0, 32'hFFFF_FF80);
        do_load(3'b100, 32'h8000_0003, 5'd7, 32'h80AA_BBCC, 1, 32'h0000_0080);
        do_load(3'b001, 32'h0000_0002, 5'd3, 32'h8001_7FFF, 2, 32'hFFFF_8001);
        do_load(3'b101, 32'h0000_0002, 5'd3, 32'h8001_7FFF, 0, 32'h0000_8001);
        do_load(3'b010, 32'h0000_0010, 5'd15, 32'h1357_9BDF, 0, 32'h1357_9BDF);
        do_load(3'b000, 32'h0000_0021, 5'd0, 32'h0000_7F00, 0, 32'h0000_007F);
        do_load(3'b111, 32'h0000_0044, 5'd8, 32'hA5A5_5A5A, 0, 32'hA5A5_5A5A);

        do_store(3'b001, 32'h0000_0102, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF, 0);
        do_store(3'b010, 32'h0000_0200, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, 5);
        do_store(3'b000, 32'h0000_0041, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 1);

        do_mis(1'b0, 3'b010, 32'h0000_0006);
        do_mis(1'b0, 3'b001, 32'h0000_0001);
        do_mis(1'b1, 3'b001, 32'h0000_0003);
        do_mis(1'b1, 3'b010, 32'h0000_0102);

        // Abandon a load in WAIT via reset, then deliver a stale rvalid.
        bus_q.push_back('{1'b0, 32'h0000_0300, 32'h0, 4'h0});
        send(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd4);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_zero_outputs("mid_reset");
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        chk("late_rvalid_wen", {31'd0, rf_wen}, 32'd0);
        chk("late_rvalid_done", {31'd0, done}, 32'd0);
        step();
        chk("late_rvalid_wen2", {31'd0, rf_wen}, 32'd0);
        do_pt(5'd9, 32'h55AA_55AA);
        do_load(3'b010, 32'h0000_0300, 5'd4, 32'h7654_3210, 0, 32'h7654_3210);

        step(); step();
        chk("ret_q_empty", ret_q.size(), 32'd0);
        chk("bus_q_empty", bus_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25040118_lsu.md
# ysyx_25040118_lsu

Load/store and writeback unit for the RV32E NPC core. It sits directly upstream of the register file. It accepts one execute-stage result at a time over a valid/ready handshake. Memory operations run on a simple req/gnt/rvalid data bus; load data is aligned and extended, and every result is driven onto the register file's single write port (`waddr`/`wdata`/`wen`).

## Interface
Parameters:
- `ADDR_W`, 32, bus address width (only 32 supported)
- `RF_AW`, 5, register address width; writes with rd ≥ 16 are forwarded unchanged, and the register file drops them

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  reset, asynchronous, active-low (one clock; async active-low reset is fixed)
- `in_valid`  in  1  execute result valid
- `in_ready`  out  1  LSU can accept; high only in IDLE
- `in_mem`  in  1  1 = memory op, 0 = pass-through writeback of `in_wdata`
- `in_store`  in  1  1 = store, 0 = load (ignored when `in_mem`=0)
- `in_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- `in_addr`  in  32  effective address
- `in_wdata`  in  32  store data, or the pass-through result
- `in_rd`  in  RF_AW  destination register
- `mem_req`  out  1  bus request, held until grant
- `mem_we`  out  1  write request
- `mem_addr`  out  32  `{in_addr[31:2],2'b00}`
- `mem_wdata`  out  32  lane-replicated store data
- `mem_wstrb`  out  4  byte strobes
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  32  read data word
- `rf_wen`  out  1  to regfile `wen`
- `rf_waddr`  out  RF_AW  to regfile `waddr`
- `rf_wdata`  out  32  to regfile `wdata`
- `done`  out  1  one-cycle pulse when an instruction retires from the LSU
- `misalign`  out  1  one-cycle pulse, coincident with `done`, on a misaligned access

## Operation
- FSM states: IDLE, REQ, WAIT, WB, ERR. The handshake fires on `in_valid & in_ready`, and all inputs are latched at that point.
- IDLE → WB when the op is pass-through.
- IDLE → ERR when the op is misaligned: H/HU/SH with `addr[0]`, or W/SW with `addr[1:0]≠0`. No bus access is made.
- IDLE → REQ for any other memory op.
- REQ: drive `mem_req`=1 together with latched `mem_we`/`mem_addr`/`mem_wdata`/`mem_wstrb`.
  - On `mem_gnt`, a store goes → IDLE with `done`=1 and no rf write.
  - On `mem_gnt`, a load goes → WAIT.
- WAIT: on `mem_rvalid`, capture the extracted load value → WB. A `mem_rvalid` in any other state is ignored, and so is a `mem_gnt` outside REQ.
- WB: `rf_wen`=1 for exactly one cycle (0 if rd==0), with `done`=1 → IDLE.
- ERR: `done`=1 and `misalign`=1, with `rf_wen`=0 → IDLE.
- Store strobes:
  - SB: `0001<<addr[1:0]`, data `{4{b}}`
  - SH: `0011<<addr[1:0]`, data `{2{h}}`
  - SW: `1111`
- Load extraction: `rdata>>(8*addr[1:0])`, then sign-extend for B/H or zero-extend for BU/HU; W is unchanged.
- Illegal `funct3` on a memory op is treated as W.

## Timing
- All outputs except `in_ready` are registered. `in_ready` = (state==IDLE).
- Reset (async, at any state, including mid-transaction) forces IDLE and clears `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `rf_wen`, `rf_waddr`, `rf_wdata`, `done` and `misalign` to 0. `in_ready`=1 after reset. A transaction in flight is abandoned, and a late `mem_rvalid` is ignored.
- Latencies, with accept in cycle N:
  - Pass-through: `rf_wen` in N+1.
  - Misaligned: `done`/`misalign` in N+1.
  - Memory op: `mem_req` rises in N+1.
  - Store: `done` in the grant cycle + 1.
  - Load: `rf_wen` in the rvalid cycle + 1.
  - Best-case load (gnt in N+1, rvalid in N+2): `rf_wen` in N+3.
- `mem_req` and its payload stay stable until `mem_gnt` is sampled high.
- Throughput: pass-through is one instruction every 2 cycles; there is no back-to-back accept.

## Structure
- `ysyx_25040118_pkg` holds:
  - the state enum
  - the funct3 constants (`F3_B`/`F3_H`/`F3_W`/`F3_BU`/`F3_HU`)
  - the strobe constants
- Sub-module `ysyx_25040118_lsu_align` (combinational) takes funct3, `addr[1:0]`, store data and rdata. It outputs `wstrb`, `wdata` lanes, the extended load value and `misalign`. The top module holds only the FSM and registers.

## Test plan
- Pass-through: `in_mem`=0, rd=5, wdata=`0x1234_5678` → `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=`0x1234_5678` one cycle after accept; `done`=1; rd=0 gives `rf_wen`=0.
- LB/LBU: addr=`0x8000_0003`, rdata=`0x80AA_BBCC`, rd=7 → `mem_addr`=`0x8000_0000`. LB writes `0xFFFF_FF80`; LBU writes `0x0000_0080`.
- SH: addr=`0x102`, data=`0xDEAD_BEEF` → `mem_wstrb`=`1100`, `mem_wdata`=`0xBEEF_BEEF`, `mem_we`=1. `done` follows the grant, with no rf write.
- Stalled grant: `mem_gnt` held low for 5 cycles → `mem_req` and its payload stay stable, `in_ready`=0, and the FSM completes once the grant arrives.
- LW at addr=`0x6` → no `mem_req`; `misalign`=`done`=1 in N+1; `rf_wen`=0.
- Reset while in WAIT, then `mem_rvalid` arrives after reset release → no `rf_wen`, all outputs 0, and a new accept works normally.
